// File: rtl/pc_unit_pkg.sv
// pc_unit_pkg: shared enable constants, state encoding and default address width for the PC unit
package pc_unit_pkg;
  localparam logic ENABLE = 1'b1;
  localparam logic DISABLE = 1'b0;
  localparam int INST_ADDR_BUS = 32;
  typedef enum logic {PC_IDLE = 1'b0, PC_RUN = 1'b1} pc_state_e;
endpackage

// File: rtl/pc_redirect_buffer.sv
// pc_redirect_buffer: holds a branch target captured during a stall until it is applied or flushed
module pc_redirect_buffer #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  capture_i,
  input  logic                  clear_i,
  input  logic [ADDR_WIDTH-1:0] target_i,
  output logic                  pending_valid_o,
  output logic [ADDR_WIDTH-1:0] pending_target_o
);
  logic                  valid_q;
  logic [ADDR_WIDTH-1:0] target_q;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q  <= 1'b0;
      target_q <= '0;
    end else if (capture_i) begin
      valid_q  <= 1'b1;
      target_q <= target_i;
    end else if (clear_i) begin
      valid_q  <= 1'b0;
    end
  end
  assign pending_valid_o  = valid_q;
  assign pending_target_o = target_q;
endmodule

// File: rtl/pc_unit.sv
// pc_unit: fetch program counter with reset vector, stall, branch/exception redirect and alignment flag
module pc_unit
  import pc_unit_pkg::*;
#(
  parameter int                    ADDR_WIDTH   = INST_ADDR_BUS,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0,
  parameter int                    INST_BYTES   = 4,
  parameter int                    ALIGN_BITS   = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  branch_valid,
  input  logic [ADDR_WIDTH-1:0] branch_target,
  input  logic                  exception_valid,
  input  logic [ADDR_WIDTH-1:0] exception_target,
  output logic [ADDR_WIDTH-1:0] program_counter,
  output logic                  chip_enable,
  output logic                  pending_valid,
  output logic                  misaligned
);
  // Low-bit mask is all zero when ALIGN_BITS = 0, which disables the check
  localparam logic [ADDR_WIDTH-1:0] LOW = ADDR_WIDTH'((64'd1 << ALIGN_BITS) - 64'd1);
  pc_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d, tgt, pend_tgt;
  logic                  ce_q, mis_q, mis_d, run, redirect, pend_v;
  assign run = state_q == PC_RUN;
  always_comb begin
    state_d  = PC_RUN;
    redirect = run & (exception_valid | (!stall & (branch_valid | pend_v)));
    tgt      = exception_valid ? exception_target : branch_valid ? branch_target : pend_tgt;
    pc_d     = redirect ? (tgt & ~LOW) : (run & !stall) ? pc_q + ADDR_WIDTH'(INST_BYTES) : pc_q;
    mis_d    = redirect & |(tgt & LOW);
  end
  pc_redirect_buffer #(.ADDR_WIDTH(ADDR_WIDTH)) u_buf (
    .clock            (clock),
    .reset            (reset),
    .capture_i        (run & stall & branch_valid & !exception_valid),
    .clear_i          (redirect),
    .target_i         (branch_target),
    .pending_valid_o  (pend_v),
    .pending_target_o (pend_tgt)
  );
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= PC_IDLE;
      pc_q    <= RESET_VECTOR;
      ce_q    <= DISABLE;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ce_q    <= ENABLE;
      mis_q   <= mis_d;
    end
  end
  assign program_counter = pc_q;
  assign chip_enable     = ce_q;
  assign pending_valid   = pend_v;
  assign misaligned      = mis_q;
endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed scenarios plus randomized run against a behavioural PC model
module tb_pc_unit;
  logic        clock = 0, reset = 1, rst_w = 1;
  logic        stall = 0, branch_valid = 0, exception_valid = 0;
  logic [31:0] branch_target = 0, exception_target = 0;
  logic [31:0] pc;
  logic        ce, pv, mis;
  logic [7:0]  pc_w;
  logic        ce_w, pv_w, mis_w;
  logic [7:0]  zero8 = 0;
  logic        zero1 = 0;
  int checks = 0, errors = 0;
  logic        m_run, m_pv, m_mis;
  logic [31:0] m_pc, m_pt;

  always #5 clock = ~clock;

  pc_unit #(.ADDR_WIDTH(32), .RESET_VECTOR(32'h100), .INST_BYTES(4), .ALIGN_BITS(2)) dut (
    .clock(clock), .reset(reset), .stall(stall), .branch_valid(branch_valid),
    .branch_target(branch_target), .exception_valid(exception_valid),
    .exception_target(exception_target), .program_counter(pc), .chip_enable(ce),
    .pending_valid(pv), .misaligned(mis));

  pc_unit #(.ADDR_WIDTH(8), .RESET_VECTOR(8'hF0), .INST_BYTES(4), .ALIGN_BITS(2)) dut_w (
    .clock(clock), .reset(rst_w), .stall(zero1), .branch_valid(zero1),
    .branch_target(zero8), .exception_valid(zero1), .exception_target(zero8),
    .program_counter(pc_w), .chip_enable(ce_w), .pending_valid(pv_w), .misaligned(mis_w));

  task automatic model_reset();
    m_run = 0; m_pc = 32'h100; m_pv = 0; m_pt = 0; m_mis = 0;
  endtask

  // Applies one edge of the next-PC priority rules to the model state
  task automatic model_edge();
    logic [31:0] t;
    logic        ap;
    t = 0; ap = 0;
    if (!m_run) begin
      m_run = 1; m_mis = 0;
    end else begin
      if (exception_valid) begin t = exception_target; ap = 1; m_pv = 0; end
      else if (stall) begin if (branch_valid) begin m_pv = 1; m_pt = branch_target; end end
      else if (branch_valid) begin t = branch_target; ap = 1; m_pv = 0; end
      else if (m_pv) begin t = m_pt; ap = 1; m_pv = 0; end
      else m_pc = m_pc + 32'd4;
      m_mis = ap && (t % 4 != 0);
      if (ap) m_pc = t - (t % 4);
    end
  endtask

  task automatic step(input logic s, input logic b, input logic [31:0] bt,
                      input logic e, input logic [31:0] et);
    stall = s; branch_valid = b; branch_target = bt; exception_valid = e; exception_target = et;
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    reset = 1;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    checks++; if (pc !== 32'h100) begin errors++; $display("FAIL reset_pc got %h want 100", pc); end
    checks++; if (ce !== 1'b0) begin errors++; $display("FAIL reset_ce got %b want 0", ce); end
    checks++; if (pv !== 1'b0) begin errors++; $display("FAIL reset_pv got %b want 0", pv); end
    checks++; if (mis !== 1'b0) begin errors++; $display("FAIL reset_mis got %b want 0", mis); end
  endtask

  task automatic test_sequential();
    reset = 0;
    step(0, 0, 0, 0, 0);
    checks++; if (ce !== 1'b1 || pc !== 32'h100) begin errors++; $display("FAIL first_fetch got ce=%b pc=%h want ce=1 pc=100", ce, pc); end
    step(0, 0, 0, 0, 0);
    checks++; if (pc !== 32'h104) begin errors++; $display("FAIL seq_104 got %h want 104", pc); end
    step(0, 0, 0, 0, 0);
    checks++; if (pc !== 32'h108) begin errors++; $display("FAIL seq_108 got %h want 108", pc); end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 0, 0);
      checks++; if (pc !== 32'h108 || ce !== 1'b1) begin errors++; $display("FAIL stall_hold got pc=%h ce=%b want pc=108 ce=1", pc, ce); end
    end
    step(0, 0, 0, 0, 0);
    checks++; if (pc !== 32'h10C) begin errors++; $display("FAIL stall_release got %h want 10c", pc); end
  endtask

  task automatic test_branch_stall();
    step(1, 1, 32'h200, 0, 0);
    checks++; if (pv !== 1'b1 || pc !== 32'h10C) begin errors++; $display("FAIL capture got pv=%b pc=%h want pv=1 pc=10c", pv, pc); end
    step(1, 1, 32'h300, 0, 0);
    checks++; if (pv !== 1'b1) begin errors++; $display("FAIL overwrite_pv got %b want 1", pv); end
    step(1, 0, 0, 0, 0);
    checks++; if (pv !== 1'b1 || pc !== 32'h10C) begin errors++; $display("FAIL pend_hold got pv=%b pc=%h want pv=1 pc=10c", pv, pc); end
    step(0, 0, 0, 0, 0);
    checks++; if (pc !== 32'h300 || pv !== 1'b0) begin errors++; $display("FAIL pend_apply got pc=%h pv=%b want pc=300 pv=0", pc, pv); end
    step(0, 0, 0, 0, 0);
    checks++; if (pc !== 32'h304) begin errors++; $display("FAIL after_pend got %h want 304", pc); end
  endtask

  task automatic test_exception_over_stall();
    step(1, 1, 32'h400, 1, 32'h80);
    checks++; if (pc !== 32'h80 || pv !== 1'b0) begin errors++; $display("FAIL exc_flush got pc=%h pv=%b want pc=80 pv=0", pc, pv); end
    step(0, 0, 0, 0, 0);
    checks++; if (pc !== 32'h84) begin errors++; $display("FAIL exc_next got %h want 84", pc); end
  endtask

  task automatic test_misaligned();
    step(0, 1, 32'h203, 0, 0);
    checks++; if (pc !== 32'h200 || mis !== 1'b1) begin errors++; $display("FAIL mis_branch got pc=%h mis=%b want pc=200 mis=1", pc, mis); end
    step(0, 0, 0, 0, 0);
    checks++; if (pc !== 32'h204 || mis !== 1'b0) begin errors++; $display("FAIL mis_pulse got pc=%h mis=%b want pc=204 mis=0", pc, mis); end
    step(1, 1, 32'h305, 0, 0);
    checks++; if (mis !== 1'b0 || pv !== 1'b1) begin errors++; $display("FAIL mis_capture got mis=%b pv=%b want mis=0 pv=1", mis, pv); end
    step(0, 0, 0, 0, 0);
    checks++; if (pc !== 32'h304 || mis !== 1'b1) begin errors++; $display("FAIL mis_pend got pc=%h mis=%b want pc=304 mis=1", pc, mis); end
  endtask

  task automatic test_wrap();
    logic [7:0] exp [6];
    exp = '{8'hF0, 8'hF4, 8'hF8, 8'hFC, 8'h00, 8'h04};
    rst_w = 1;
    @(posedge clock);
    #1 rst_w = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clock);
      #1;
      checks++; if (pc_w !== exp[i] || ce_w !== 1'b1 || mis_w !== 1'b0) begin errors++; $display("FAIL wrap_%0d got pc=%h ce=%b mis=%b want pc=%h ce=1 mis=0", i, pc_w, ce_w, mis_w, exp[i]); end
    end
  endtask

  task automatic test_async_reset();
    step(1, 1, 32'h500, 0, 0);
    #2 reset = 1;
    #1;
    model_reset();
    checks++; if (pc !== 32'h100 || ce !== 1'b0 || pv !== 1'b0 || mis !== 1'b0) begin errors++; $display("FAIL async_reset got pc=%h ce=%b pv=%b mis=%b want pc=100 ce=0 pv=0 mis=0", pc, ce, pv, mis); end
    stall = 0; branch_valid = 0;
    @(posedge clock);
    #1 reset = 0;
    step(0, 0, 0, 0, 0);
    checks++; if (pc !== 32'h100 || ce !== 1'b1) begin errors++; $display("FAIL post_reset got pc=%h ce=%b want pc=100 ce=1", pc, ce); end
    step(0, 0, 0, 0, 0);
    checks++; if (pc !== 32'h104) begin errors++; $display("FAIL post_reset_seq got %h want 104", pc); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(2, 0) == 0, $urandom_range(3, 0) == 0, $urandom,
           $urandom_range(9, 0) == 0, $urandom);
      checks++;
      if (pc !== m_pc || ce !== m_run || pv !== m_pv || mis !== m_mis) begin
        errors++;
        $display("FAIL random_%0d got pc=%h ce=%b pv=%b mis=%b want pc=%h ce=%b pv=%b mis=%b",
                 i, pc, ce, pv, mis, m_pc, m_run, m_pv, m_mis);
      end
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_branch_stall();
    test_exception_over_stall();
    test_misaligned();
    test_wrap();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
